// File: rtl/iir_pkg.sv
// Shared widths, state encoding and sample type for the sequential biquad.
// The sample width here is the default build (WIDTH_H=5, WIDTH_W=20).
package iir_pkg;

    localparam int D     = 25;
    localparam int ACC_W = 2 * D + 3;

    typedef logic signed [D-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Five products of 2d bits each need three guard bits to sum without overflow.
    function automatic int acc_width(input int d);
        return 2 * d + 3;
    endfunction

endpackage

// File: rtl/iir_biquad_seq_mac.sv
// Single signed multiplier with add/subtract accumulation.
// The combinational sum exposes the result including the current product.
module fx_mac #(
    parameter int WIDTH = 25,
    parameter int ACC_W = 53
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    en,
    input  logic                    sub,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [ACC_W-1:0] acc,
    output logic signed [ACC_W-1:0] sum
);

    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]   prod_ext;

    assign prod     = a * b;
    assign prod_ext = {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
    assign sum      = sub ? (acc - prod_ext) : (acc + prod_ext);

    always_ff @(posedge clk) begin
        if (rst || clear)
            acc <= '0;
        else if (en)
            acc <= sum;
    end

endmodule

// File: rtl/iir_biquad_seq.sv
// Direct Form I biquad sharing one multiplier over five MAC cycles per sample.
// Define IIR_BIQUAD_SAT_EN to saturate the output; otherwise it wraps.
module iir_biquad_seq
    import iir_pkg::*;
#(
    parameter int WIDTH_H = 5,
    parameter int WIDTH_W = 20,
    parameter logic signed [WIDTH_H+WIDTH_W-1:0] B0 = 1048576,
    parameter logic signed [WIDTH_H+WIDTH_W-1:0] B1 = 0,
    parameter logic signed [WIDTH_H+WIDTH_W-1:0] B2 = 0,
    parameter logic signed [WIDTH_H+WIDTH_W-1:0] A1 = 0,
    parameter logic signed [WIDTH_H+WIDTH_W-1:0] A2 = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic signed [WIDTH_H+WIDTH_W-1:0] data_i,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic signed [WIDTH_H+WIDTH_W-1:0] data_o
);

    localparam int DW = WIDTH_H + WIDTH_W;
    localparam int AW = acc_width(DW);

    localparam logic signed [AW-1:0] MAXV = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    state_t state;
    logic [2:0] cnt;
    logic signed [DW-1:0] x0, x1, x2, y1, y2;
    logic signed [DW-1:0] opa, opb, y_new;
    logic sub;
    logic signed [AW-1:0] acc, sum, scaled;
    logic accept;

    assign in_ready = (state == IDLE) && !rst;
    assign accept   = in_valid && in_ready;

    always_comb begin
        opa = B0;
        opb = x0;
        sub = 1'b0;
        case (cnt)
            3'd1: begin opa = B1; opb = x1; end
            3'd2: begin opa = B2; opb = x2; end
            3'd3: begin opa = A1; opb = y1; sub = 1'b1; end
            3'd4: begin opa = A2; opb = y2; sub = 1'b1; end
            default: ;
        endcase
    end

    fx_mac #(.WIDTH(DW), .ACC_W(AW)) u_mac (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .en    (state == MAC),
        .sub   (sub),
        .a     (opa),
        .b     (opb),
        .acc   (acc),
        .sum   (sum)
    );

    // The last product is folded in combinationally so the result lands on the 5th edge.
    assign scaled = sum >>> WIDTH_W;

`ifdef IIR_BIQUAD_SAT_EN
    always_comb begin
        if (scaled > MAXV)
            y_new = MAXV[DW-1:0];
        else if (scaled < MINV)
            y_new = MINV[DW-1:0];
        else
            y_new = scaled[DW-1:0];
    end
`else
    logic scaled_unused;
    assign scaled_unused = ^{scaled[AW-1:DW], MAXV, MINV, acc};
    assign y_new = scaled[DW-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            data_o    <= '0;
            x0        <= '0;
            x1        <= '0;
            x2        <= '0;
            y1        <= '0;
            y2        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        x0    <= data_i;
                        cnt   <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    if (cnt == 3'd4) begin
                        state     <= OUT;
                        out_valid <= 1'b1;
                        data_o    <= y_new;
                        x2        <= x1;
                        x1        <= x0;
                        y2        <= y1;
                        y1        <= y_new;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iir_biquad_seq.sv
// Bench for iir_biquad_seq: four coefficient sets checked against an arithmetic model.
// Expected overflow handling follows IIR_BIQUAD_SAT_EN.
module tb_iir_biquad_seq;

    localparam longint CB0 [4] = '{1048576, 1048576, 2097152, 786432};
    localparam longint CB1 [4] = '{0, 0, 0, -314573};
    localparam longint CB2 [4] = '{0, 0, 0, 209715};
    localparam longint CA1 [4] = '{0, -524288, 0, -943718};
    localparam longint CA2 [4] = '{0, 0, 0, 419430};

    logic clk, rst;
    logic vin [4];
    logic rdy [4];
    logic ovld [4];
    logic ordy [4];
    logic signed [24:0] din [4];
    logic signed [24:0] dout [4];

    int total = 0, passed = 0, fails = 0;
    longint hx1 [4], hx2 [4], hy1 [4], hy2 [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    iir_biquad_seq u0 (.clk(clk), .rst(rst), .in_valid(vin[0]), .in_ready(rdy[0]), .data_i(din[0]),
                       .out_valid(ovld[0]), .out_ready(ordy[0]), .data_o(dout[0]));
    iir_biquad_seq #(.B0(25'sd1048576), .A1(-25'sd524288)) u1 (
        .clk(clk), .rst(rst), .in_valid(vin[1]), .in_ready(rdy[1]), .data_i(din[1]),
        .out_valid(ovld[1]), .out_ready(ordy[1]), .data_o(dout[1]));
    iir_biquad_seq #(.B0(25'sd2097152)) u2 (
        .clk(clk), .rst(rst), .in_valid(vin[2]), .in_ready(rdy[2]), .data_i(din[2]),
        .out_valid(ovld[2]), .out_ready(ordy[2]), .data_o(dout[2]));
    iir_biquad_seq #(.B0(25'sd786432), .B1(-25'sd314573), .B2(25'sd209715),
                     .A1(-25'sd943718), .A2(25'sd419430)) u3 (
        .clk(clk), .rst(rst), .in_valid(vin[3]), .in_ready(rdy[3]), .data_i(din[3]),
        .out_valid(ovld[3]), .out_ready(ordy[3]), .data_o(dout[3]));

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 4; k++) begin
            hx1[k] = 0; hx2[k] = 0; hy1[k] = 0; hy2[k] = 0;
        end
    endfunction

    // y = sum of coefficient*history products, floor-divided by 2^20, then clamped or wrapped.
    function automatic longint model(input int k, input longint x);
        longint a, s, y;
        a = CB0[k]*x + CB1[k]*hx1[k] + CB2[k]*hx2[k] - CA1[k]*hy1[k] - CA2[k]*hy2[k];
        s = a >>> 20;
`ifdef IIR_BIQUAD_SAT_EN
        if (s > 16777215) y = 16777215;
        else if (s < -16777216) y = -16777216;
        else y = s;
`else
        y = s & 64'h1FFFFFF;
        if (y >= 16777216) y = y - 33554432;
`endif
        hx2[k] = hx1[k]; hx1[k] = x;
        hy2[k] = hy1[k]; hy1[k] = y;
        return y;
    endfunction

    task automatic accept(input int k, input longint x, output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        while (!rdy[k] && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = rdy[k];
        if (ok) begin
            vin[k] = 1'b1;
            din[k] = x[24:0];
            @(posedge clk);
            #1 vin[k] = 1'b0;
        end
    endtask

    task automatic process_sample(input int k, input longint x, input int stall, input string tag);
        longint exp;
        int lat;
        bit ok, stable;
        exp = model(k, x);
        ordy[k] = (stall == 0);
        accept(k, x, ok);
        chk({tag, "_accept"}, longint'(ok), 1);
        if (!ok) return;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (ovld[k]) begin lat = i; break; end
        end
        chk({tag, "_latency"}, lat, 5);
        chk({tag, "_data"}, longint'(dout[k]), exp);
        if (stall > 0) begin
            stable = 1'b1;
            repeat (stall) begin
                @(posedge clk); #1;
                if (!ovld[k] || longint'(dout[k]) != exp || rdy[k]) stable = 1'b0;
            end
            chk({tag, "_stall_hold"}, longint'(stable), 1);
            ordy[k] = 1'b1;
        end
        @(posedge clk); #1;
        chk({tag, "_once"}, longint'(ovld[k]), 0);
        chk({tag, "_data_hold"}, longint'(dout[k]), exp);
    endtask

    initial begin
        longint s [8];
        longint q [$];
        int acyc [8];
        int na, no, seen;
        bit ok, acc_now;

        for (int k = 0; k < 4; k++) begin
            vin[k] = 1'b0; ordy[k] = 1'b1; din[k] = '0;
        end
        model_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", longint'(rdy[0]), 0);
        chk("rst_out_valid", longint'(ovld[0]), 0);
        chk("rst_data_o", longint'(dout[0]), 0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", longint'(rdy[0]), 1);

        process_sample(0, 1048576, 0, "pass_1p0");
        process_sample(0, -2621440, 0, "pass_m2p5");
        process_sample(0, 262144, 0, "pass_0p25");

        process_sample(1, 1048576, 0, "imp0");
        process_sample(1, 0, 0, "imp1");
        process_sample(1, 0, 0, "imp2");
        process_sample(1, 0, 0, "imp3");

        process_sample(2, 10485760, 0, "ovf_pos");
        process_sample(2, -10485760, 0, "ovf_neg");

        process_sample(0, 3145728, 10, "stall");

        // Reset lands while the sample is in its third MAC cycle.
        ordy[1] = 1'b1;
        accept(1, 1048576, ok);
        chk("rstmid_accept", longint'(ok), 1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("rstmid_in_ready", longint'(rdy[0]), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (ovld[1]) seen++;
        end
        chk("rstmid_no_out", seen, 0);
        process_sample(1, 1048576, 0, "fresh0");
        process_sample(1, 0, 0, "fresh1");

        for (int i = 0; i < 8; i++) begin
            s[i] = longint'($urandom_range(0, 16777215)) - 8388608;
            q.push_back(model(0, s[i]));
        end
        na = 0; no = 0;
        ordy[0] = 1'b1;
        din[0] = s[0][24:0];
        vin[0] = 1'b1;
        for (int c = 0; c < 200 && no < 8; c++) begin
            @(negedge clk);
            if (ovld[0]) begin
                chk("tp_out", longint'(dout[0]), q[no]);
                no++;
            end
            acc_now = vin[0] && rdy[0];
            @(posedge clk); #1;
            if (acc_now) begin
                acyc[na] = c;
                na++;
                if (na < 8) din[0] = s[na][24:0];
                else vin[0] = 1'b0;
            end
        end
        vin[0] = 1'b0;
        chk("tp_accepts", na, 8);
        chk("tp_outputs", no, 8);
        for (int i = 1; i < 8 && i < na; i++)
            chk("tp_gap", acyc[i] - acyc[i-1], 7);

        for (int i = 0; i < 25; i++) begin
            longint x;
            if (i % 8 == 7) x = longint'($urandom_range(0, 33554431)) - 16777216;
            else x = longint'($urandom_range(0, 8388607)) - 4194304;
            process_sample(3, x, int'($urandom_range(0, 2)) * 2, "rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
